// File: rtl/usermem_ctrl.sv
// rtl/usermem_ctrl.sv - parametrised user data memory with req/ready handshake,
// wait states, post-reset clear sweep and a write-protected upper region.
module usermem_ctrl #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int WAIT_STATES    = 0,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int PROT_BASE      = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] uaddr,
    input  logic [DATA_W-1:0] udata_i,
    output logic [DATA_W-1:0] udata_o,
    output logic              ready,
    output logic              err,
    output logic              busy
);
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_ACK} state_t;
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] udata_q, udata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              do_op;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_data;
    logic              op_rw;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rw_d       = rw_q;
        udata_d    = udata_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clr_cnt_q[ADDR_W-1:0];
        mem_wdata  = '0;
        do_op      = 1'b0;
        op_addr    = addr_q;
        op_data    = data_q;
        op_rw      = rw_q;

        unique case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
                // Carry into the extra MSB marks the last word just written.
                if (clr_cnt_d[ADDR_W]) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req) begin
                    addr_d     = uaddr;
                    data_d     = udata_i;
                    rw_d       = rw;
                    wait_cnt_d = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        // No wait states: perform the access from the live inputs.
                        op_addr = uaddr;
                        op_data = udata_i;
                        op_rw   = rw;
                        do_op   = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_d == 4'd0) begin
                    do_op   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        if (do_op) begin
            ready_d = 1'b1;
            if (!op_rw) begin
                udata_d = mem_q[op_addr];
            end else if (32'(op_addr) < PROT_BASE) begin
                mem_we    = 1'b1;
                mem_waddr = op_addr;
                mem_wdata = op_data;
            end else begin
                err_d = 1'b1;
            end
        end

        busy_d = (state_d == S_CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            clr_cnt_q  <= '0;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rw_q       <= 1'b0;
            udata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= CLEAR_ON_RESET;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rw_q       <= rw_d;
            udata_q    <= udata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign udata_o = udata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign busy    = busy_q;
endmodule
